tdm_demux4: RTL and testbench

- 1-to-4 time-division demultiplexer. It is the receive end of a 4:1 mux link whose select rotates 00→01→10→11.
- Takes one serial beat per slot and reassembles four channel values into a parallel bus, the same shape as the mux's d input.
- Publishes each complete frame atomically with a one-cycle valid pulse.
- Sits after the link, ahead of channel consumers.

---
 rtl/tdm_pkg.sv | 7 +
 rtl/tdm_slot_ctr.sv | 15 +
 rtl/tdm_demux4.sv | 65 ++++++
 tb/tb_tdm_demux4.sv | 138 +++++++++++++
 4 files changed

// File: rtl/tdm_pkg.sv
// tdm_pkg: shared constants and FSM state type for the TDM demultiplexer.
package tdm_pkg;
  localparam int N_CH      = 4;
  localparam int SEL_W     = 2;
  localparam int ERR_CNT_W = 8;
  typedef enum logic {HUNT, RUN} state_t;
endpackage

// File: rtl/tdm_slot_ctr.sv
// tdm_slot_ctr: wrapping slot counter; load1 restarts at slot 1 after a slot-0 beat.
module tdm_slot_ctr
  import tdm_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             load1,
  output logic [SEL_W-1:0] slot
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) slot <= '0;
    else if (load1) slot <= SEL_W'(1);
    else if (inc) slot <= slot + 1'b1;
endmodule

// File: rtl/tdm_demux4.sv
// tdm_demux4: 1-to-4 TDM demultiplexer that reassembles four slot beats into one frame.
// Define TDM_DEMUX_ERR_CNT_EN to add err_cnt, a saturating count of sync_err pulses.
module tdm_demux4
  import tdm_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  din_valid,
  input  logic [WIDTH-1:0]      din,
  input  logic                  frame_start,
`ifdef TDM_DEMUX_ERR_CNT_EN
  output logic [ERR_CNT_W-1:0]  err_cnt,
`endif
  output logic [SEL_W-1:0]      sel,
  output logic [N_CH*WIDTH-1:0] d,
  output logic                  d_valid,
  output logic                  locked,
  output logic                  sync_err
);
  state_t state_q, state_d;
  logic [WIDTH-1:0] stage [N_CH-1];
  logic inc, load1, stage_we, publish, err;
  logic [SEL_W-1:0] wr_idx;
  tdm_slot_ctr u_slot_ctr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (inc),
    .load1 (load1),
    .slot  (sel)
  );
  always_comb begin
    err      = din_valid && state_q == RUN && frame_start && sel != '0;
    load1    = err || (din_valid && state_q == HUNT && frame_start);
    inc      = din_valid && state_q == RUN && !err;
    publish  = inc && sel == SEL_W'(N_CH - 1);
    stage_we = load1 || (inc && !publish);
    wr_idx   = load1 ? '0 : sel;
    state_d  = load1 ? RUN : state_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q  <= HUNT;
      d        <= '0;
      d_valid  <= 1'b0;
      sync_err <= 1'b0;
      for (int i = 0; i < N_CH - 1; i++) stage[i] <= '0;
    end else begin
      state_q  <= state_d;
      d_valid  <= publish;
      sync_err <= err;
      if (stage_we) stage[wr_idx] <= din;
      if (publish) begin
        for (int i = 0; i < N_CH - 1; i++) d[i*WIDTH +: WIDTH] <= stage[i];
        d[(N_CH-1)*WIDTH +: WIDTH] <= din;
      end
    end
  assign locked = state_q == RUN;
`ifdef TDM_DEMUX_ERR_CNT_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) err_cnt <= '0;
    else if (err && err_cnt != '1) err_cnt <= err_cnt + 1'b1;
`endif
endmodule

// File: tb/tb_tdm_demux4.sv
// tb_tdm_demux4: directed and random checks of tdm_demux4 against a frame-level model.
module tb_tdm_demux4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic din_valid = 1'b0;
  logic [0:0] din = '0;
  logic frame_start = 1'b0;
  logic [1:0] sel;
  logic [3:0] d;
  logic d_valid, locked, sync_err;
`ifdef TDM_DEMUX_ERR_CNT_EN
  logic [7:0] err_cnt;
`endif
  int n_chk = 0;
  int n_fail = 0;
  bit m_locked;
  int m_pos;
  bit mslot [4];
  logic [3:0] m_d;
  bit m_dv, m_err;
  int m_errs;

  tdm_demux4 #(.WIDTH(1)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .din_valid   (din_valid),
    .din         (din),
    .frame_start (frame_start),
`ifdef TDM_DEMUX_ERR_CNT_EN
    .err_cnt     (err_cnt),
`endif
    .sel         (sel),
    .d           (d),
    .d_valid     (d_valid),
    .locked      (locked),
    .sync_err    (sync_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_locked = 0; m_pos = 0; m_d = '0; m_dv = 0; m_err = 0; m_errs = 0;
    for (int i = 0; i < 4; i++) mslot[i] = 0;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".d"}, 32'(d), 32'(m_d));
    check({tag, ".d_valid"}, 32'(d_valid), 32'(m_dv));
    check({tag, ".sync_err"}, 32'(sync_err), 32'(m_err));
    check({tag, ".locked"}, 32'(locked), 32'(m_locked));
    check({tag, ".sel"}, 32'(sel), 32'(m_pos));
`ifdef TDM_DEMUX_ERR_CNT_EN
    check({tag, ".err_cnt"}, 32'(err_cnt), 32'(m_errs));
`endif
  endtask

  task automatic step(input bit v, input bit fs, input bit b, input string tag);
    din_valid = v; frame_start = fs; din = b;
    @(posedge clk);
    m_dv = 0; m_err = 0;
    if (v) begin
      if (!m_locked) begin
        if (fs) begin m_locked = 1; mslot[0] = b; m_pos = 1; end
      end else if (fs && m_pos != 0) begin
        m_err = 1; mslot[0] = b; m_pos = 1;
        if (m_errs < 255) m_errs++;
      end else begin
        mslot[m_pos] = b;
        if (m_pos == 3) begin
          m_d = {mslot[3], mslot[2], mslot[1], mslot[0]};
          m_dv = 1; m_pos = 0;
        end else m_pos++;
      end
    end
    #1;
    check_all(tag);
  endtask

  task automatic gap(input int n, input string tag);
    for (int i = 0; i < n; i++) step(0, $urandom_range(1, 0), $urandom_range(1, 0), tag);
  endtask

  initial begin
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("por");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step(1, 0, 1, "hunt");
    step(1, 1, 0, "f1b0");
    step(1, 0, 1, "f1b1");
    step(1, 0, 0, "f1b2");
    step(1, 0, 1, "f1b3");
    check("f1.d_const", 32'(d), 32'h a);
    step(0, 0, 0, "f1.after");
    step(1, 1, 0, "f2b0"); gap(2, "f2g");
    step(1, 0, 1, "f2b1"); gap(2, "f2g");
    step(1, 0, 0, "f2b2"); gap(2, "f2g");
    step(1, 0, 1, "f2b3");
    check("f2.d_const", 32'(d), 32'h a);
    step(1, 0, 1, "e.b0");
    step(1, 0, 1, "e.b1");
    step(1, 1, 0, "e.fs");
    check("e.sync_const", 32'(sync_err), 32'h1);
    check("e.hold_const", 32'(d), 32'h a);
    step(1, 0, 0, "e.b1r");
    step(1, 0, 1, "e.b2r");
    step(1, 0, 1, "e.b3r");
    check("e.d_const", 32'(d), 32'h c);
    step(1, 1, 1, "r.b0");
    step(1, 0, 1, "r.b1");
    rst_n = 1'b0;
    #1;
    m_reset();
    check_all("async_rst");
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    step(1, 0, 1, "r.ignored");
    step(1, 1, 0, "x.b0");
    step(1, 0, 1, "x.b1");
    step(1, 0, 1, "x.b2");
    step(1, 1, 1, "x.fs3");
    for (int i = 0; i < 400; i++)
      step($urandom_range(3, 0) != 0, $urandom_range(7, 0) == 0, $urandom_range(1, 0), "rand");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
